// File: rtl/filter2d_feeder.sv
// Frame source for the 3x3 convolution engine: loads the nine kernel weights,
// then streams one frame row-major from a synchronous-read memory as paced strobes.
module filter2d_feeder #(
  parameter int BITWIDTH = 8,
  parameter int COLS     = 640,
  parameter int ROWS     = 480,
  parameter int ADDR_W   = 20,
  parameter int GAP      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  stall,
  input  logic [9*BITWIDTH-1:0] weights,
  input  logic [ADDR_W-1:0]     frame_base,
  output logic                  mem_rd_en,
  output logic [ADDR_W-1:0]     mem_addr,
  input  logic [BITWIDTH-1:0]   mem_rdata,
  output logic                  weight_in_valid,
  output logic [3:0]            weight_addr,
  output logic [BITWIDTH-1:0]   weight_data,
  output logic                  process_enable,
  output logic                  data_in_valid,
  output logic [BITWIDTH-1:0]   data_in,
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned NPIX = COLS * ROWS;
  localparam logic [ADDR_W-1:0] LAST_INDEX = ADDR_W'(NPIX - 1);
  localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [GAP_W-1:0] GAP_RELOAD = GAP_W'(GAP - 1);
  localparam logic [3:0] LAST_SLOT = 4'd8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD_W = 3'd1,
    ST_STREAM = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  state_t                state_reg;
  state_t                state_next;
  logic [BITWIDTH-1:0]   weight_slot [9];
  logic [BITWIDTH-1:0]   weight_reg  [9];
  logic [ADDR_W-1:0]     base_reg;
  logic [ADDR_W-1:0]     index_reg;
  logic [3:0]            wslot_reg;
  logic [GAP_W-1:0]      gap_reg;
  logic                  rd_pipe_reg;
  logic                  valid_reg;
  logic [BITWIDTH-1:0]   data_reg;
  logic                  accept;
  logic                  issue;

  // Abort outranks start even in IDLE, so a same-cycle abort blocks the frame.
  assign accept = (state_reg == ST_IDLE) && start && !abort;
  assign issue  = (state_reg == ST_STREAM) && (gap_reg == '0) && !stall;

  for (genvar gi = 0; gi < 9; gi++) begin : g_slot
    assign weight_slot[gi] = weights[gi*BITWIDTH +: BITWIDTH];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    if (abort && state_reg != ST_IDLE) begin
      state_next = ST_IDLE;
    end else begin
      case (state_reg)
        ST_IDLE:   if (accept) state_next = ST_LOAD_W;
        ST_LOAD_W: if (wslot_reg == LAST_SLOT) state_next = ST_STREAM;
        ST_STREAM: if (issue && index_reg == LAST_INDEX) state_next = ST_DRAIN;
        // Last strobe is on the wire and nothing remains behind it.
        ST_DRAIN:  if (valid_reg && !rd_pipe_reg) state_next = ST_DONE;
        ST_DONE:   state_next = ST_IDLE;
        default:   state_next = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    weight_in_valid = 1'b0;
    weight_addr     = 4'd0;
    weight_data     = '0;
    mem_rd_en       = 1'b0;
    mem_addr        = '0;
    process_enable  = 1'b0;
    done            = 1'b0;
    busy            = (state_reg != ST_IDLE);
    case (state_reg)
      ST_LOAD_W: begin
        weight_in_valid = 1'b1;
        weight_addr     = wslot_reg;
        weight_data     = weight_reg[wslot_reg];
      end
      ST_STREAM: begin
        process_enable = 1'b1;
        if (issue) begin
          mem_rd_en = 1'b1;
          mem_addr  = base_reg + index_reg;
        end
      end
      ST_DRAIN: process_enable = 1'b1;
      ST_DONE:  done = 1'b1;
      default:  ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < 9; k++) weight_reg[k] <= '0;
      base_reg  <= '0;
      index_reg <= '0;
      wslot_reg <= 4'd0;
    end else begin
      if (accept) begin
        for (int k = 0; k < 9; k++) weight_reg[k] <= weight_slot[k];
        base_reg  <= frame_base;
        index_reg <= '0;
        wslot_reg <= 4'd0;
      end else begin
        if (state_reg == ST_LOAD_W) wslot_reg <= wslot_reg + 4'd1;
        if (issue) index_reg <= index_reg + ADDR_W'(1);
      end
    end
  end

  // Gap counter parks at 0 outside STREAM so the first slot opens immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gap_reg <= '0;
    end else if (state_reg != ST_STREAM) begin
      gap_reg <= '0;
    end else if (issue) begin
      gap_reg <= GAP_RELOAD;
    end else if (gap_reg != '0) begin
      gap_reg <= gap_reg - GAP_W'(1);
    end
  end

  // Two-stage read pipeline: issue -> capture -> strobe. Abort flushes it but
  // leaves the last captured pixel on data_in.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_pipe_reg <= 1'b0;
      valid_reg   <= 1'b0;
      data_reg    <= '0;
    end else begin
      rd_pipe_reg <= issue && !abort;
      valid_reg   <= rd_pipe_reg && !abort;
      if (rd_pipe_reg && !abort) data_reg <= mem_rdata;
    end
  end

  assign data_in_valid = valid_reg;
  assign data_in       = data_reg;

endmodule

// File: tb/tb_filter2d_feeder.sv
// Scoreboard bench: stimulus pushes expected weights/addresses/pixels, monitors
// pop and compare whenever the feeders present output.
module tb_filter2d_feeder;
  localparam int BW    = 8;
  localparam int COLS  = 4;
  localparam int ROWS  = 3;
  localparam int AW    = 10;
  localparam int GAP_A = 3;
  localparam int GAP_B = 1;
  localparam int NPIX  = COLS * ROWS;
  localparam int MSIZE = 1 << AW;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic            start, abort, stall;
  logic [9*BW-1:0] weights;
  logic [AW-1:0]   frame_base;
  logic            mem_rd_en;
  logic [AW-1:0]   mem_addr;
  logic [BW-1:0]   mem_rdata = '0;
  logic            weight_in_valid;
  logic [3:0]      weight_addr;
  logic [BW-1:0]   weight_data;
  logic            process_enable, data_in_valid, busy, done;
  logic [BW-1:0]   data_in;

  logic            b_start;
  logic [9*BW-1:0] b_weights;
  logic [AW-1:0]   b_frame_base;
  logic            b_mem_rd_en;
  logic [AW-1:0]   b_mem_addr;
  logic [BW-1:0]   b_mem_rdata = '0;
  logic            b_weight_in_valid;
  logic [3:0]      b_weight_addr;
  logic [BW-1:0]   b_weight_data;
  logic            b_process_enable, b_data_in_valid, b_busy, b_done;
  logic [BW-1:0]   b_data_in;

  filter2d_feeder #(.BITWIDTH(BW), .COLS(COLS), .ROWS(ROWS), .ADDR_W(AW), .GAP(GAP_A)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .stall(stall),
    .weights(weights), .frame_base(frame_base),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .weight_in_valid(weight_in_valid), .weight_addr(weight_addr), .weight_data(weight_data),
    .process_enable(process_enable), .data_in_valid(data_in_valid), .data_in(data_in),
    .busy(busy), .done(done)
  );

  filter2d_feeder #(.BITWIDTH(BW), .COLS(COLS), .ROWS(ROWS), .ADDR_W(AW), .GAP(GAP_B)) dut_b (
    .clk(clk), .rst(rst), .start(b_start), .abort(1'b0), .stall(1'b0),
    .weights(b_weights), .frame_base(b_frame_base),
    .mem_rd_en(b_mem_rd_en), .mem_addr(b_mem_addr), .mem_rdata(b_mem_rdata),
    .weight_in_valid(b_weight_in_valid), .weight_addr(b_weight_addr), .weight_data(b_weight_data),
    .process_enable(b_process_enable), .data_in_valid(b_data_in_valid), .data_in(b_data_in),
    .busy(b_busy), .done(b_done)
  );

  logic [BW-1:0] mem [MSIZE];
  always @(posedge clk) if (mem_rd_en) mem_rdata <= mem[mem_addr];
  always @(posedge clk) if (b_mem_rd_en) b_mem_rdata <= mem[b_mem_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int passes = 0;
  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  int exp_w[$];
  int exp_addr[$];
  int exp_pix[$];
  int b_exp[$];
  int rd_cycles[$];
  int vld_cycles[$];
  int b_vld[$];
  int done_cnt, done_cyc, unstable, spacing_bad, last_vld, b_done_cyc;
  bit nostall;
  logic [BW-1:0] last_data;

  always @(negedge clk) begin
    if (rst) begin
      if (weight_in_valid) begin
        if (exp_w.size() == 0) check("unexpected_weight_write", 1, 0);
        else begin
          int e;
          e = exp_w.pop_front();
          check("weight_addr", int'(weight_addr), e >> 8);
          check("weight_data", int'(weight_data), e & 255);
        end
      end
      if (mem_rd_en) begin
        rd_cycles.push_back(cyc);
        if (exp_addr.size() == 0) check("unexpected_mem_rd_en", 1, 0);
        else check("mem_addr", int'(mem_addr), exp_addr.pop_front());
      end
      if (data_in_valid) begin
        vld_cycles.push_back(cyc);
        if (exp_pix.size() == 0) check("unexpected_strobe", 1, 0);
        else check("data_in", int'(data_in), exp_pix.pop_front());
        if (nostall && last_vld >= 0 && cyc - last_vld != GAP_A) spacing_bad++;
        last_vld  = cyc;
        last_data = data_in;
      end else if (data_in !== last_data) begin
        unstable++;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      if (b_data_in_valid) begin
        b_vld.push_back(cyc);
        if (b_exp.size() == 0) check("b_unexpected_strobe", 1, 0);
        else check("b_data_in", int'(b_data_in), b_exp.pop_front());
      end
      if (b_done) b_done_cyc = cyc;
    end
  end

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_stats();
    rd_cycles.delete();
    vld_cycles.delete();
    done_cnt = 0;
    done_cyc = -1;
    unstable = 0;
    spacing_bad = 0;
    last_vld = -1;
  endtask

  function automatic logic [9*BW-1:0] rand_weights();
    logic [9*BW-1:0] w;
    for (int k = 0; k < 9; k++) w[k*BW +: BW] = BW'($urandom);
    return w;
  endfunction

  // Reference: weights go out in slot order, then pixels base+i (mod 2^AW) in row-major order.
  task automatic push_frame(input logic [9*BW-1:0] w, input int base);
    for (int k = 0; k < 9; k++) exp_w.push_back((k << 8) | int'(w[k*BW +: BW]));
    for (int i = 0; i < NPIX; i++) begin
      int a;
      a = (base + i) % MSIZE;
      exp_addr.push_back(a);
      exp_pix.push_back(int'(mem[a]));
    end
  endtask

  task automatic issue_start(input logic [9*BW-1:0] w, input int base, output int s);
    weights    = w;
    frame_base = AW'(base);
    start      = 1'b1;
    s          = cyc;
    step();
    start      = 1'b0;
  endtask

  task automatic run_frame(input int base, input bit do_stall, input bit poke_start, input string tag);
    logic [9*BW-1:0] w;
    int s, t, exp_done;
    w = rand_weights();
    clear_stats();
    nostall = !do_stall;
    push_frame(w, base);
    issue_start(w, base, s);
    t = 0;
    while (done_cyc < 0 && t < 600) begin
      stall = do_stall && (cyc >= s + 18) && (cyc <= s + 22);
      start = poke_start && (cyc == s + 20);
      if (start) begin
        frame_base = AW'(base + 77);
        weights    = rand_weights();
      end
      step();
      t++;
    end
    stall = 1'b0;
    start = 1'b0;
    // A 5-cycle stall over the 4th slot delays the rest of the frame by 4 cycles.
    exp_done = s + 13 + (NPIX - 1) * GAP_A + (do_stall ? 4 : 0);
    check({tag, "_first_rd_cycle"}, rd_cycles.size() > 0 ? rd_cycles[0] - s : -1, 10);
    check({tag, "_first_strobe_cycle"}, vld_cycles.size() > 0 ? vld_cycles[0] - s : -1, 12);
    check({tag, "_done_cycle"}, done_cyc - s, exp_done - s);
    check({tag, "_read_count"}, rd_cycles.size(), NPIX);
    check({tag, "_strobe_count"}, vld_cycles.size(), NPIX);
    check({tag, "_data_in_unstable"}, unstable, 0);
    if (!do_stall) check({tag, "_spacing_errors"}, spacing_bad, 0);
    if (do_stall && rd_cycles.size() >= 4 && vld_cycles.size() >= 3) begin
      check({tag, "_rd2_cycle"}, rd_cycles[2] - s, 16);
      check({tag, "_rd3_cycle"}, rd_cycles[3] - s, 23);
      check({tag, "_inflight_strobe2_cycle"}, vld_cycles[2] - s, 18);
    end
    step(6);
    check({tag, "_done_pulses"}, done_cnt, 1);
    check({tag, "_busy_after"}, int'(busy), 0);
    check({tag, "_leftover_expect"}, exp_w.size() + exp_addr.size() + exp_pix.size(), 0);
  endtask

  task automatic flush_expect();
    exp_w.delete();
    exp_addr.delete();
    exp_pix.delete();
  endtask

  initial begin
    int s, t, n, base;
    logic [9*BW-1:0] w;
    for (int i = 0; i < MSIZE; i++) mem[i] = BW'($urandom);
    rst = 1'b0; start = 1'b0; abort = 1'b0; stall = 1'b0;
    weights = '0; frame_base = '0;
    b_start = 1'b0; b_weights = '0; b_frame_base = '0;
    last_data = '0; nostall = 1'b1;
    clear_stats();
    step(3);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    check("reset_process_enable", int'(process_enable), 0);
    check("reset_weight_in_valid", int'(weight_in_valid), 0);
    check("reset_mem_rd_en", int'(mem_rd_en), 0);
    check("reset_data_in_valid", int'(data_in_valid), 0);
    check("reset_data_in", int'(data_in), 0);
    rst = 1'b1;
    step(2);

    // Fixed weight pattern 11..99 in slots 0..8.
    w = '0;
    for (int k = 0; k < 9; k++) w[k*BW +: BW] = BW'(8'h11 * (k + 1));
    clear_stats();
    push_frame(w, 'h100);
    issue_start(w, 'h100, s);
    step(9 + (NPIX - 1) * GAP_A + 8);
    check("fixed_done_pulses", done_cnt, 1);

    run_frame('h100, 1'b0, 1'b1, "frame_poke_start");
    run_frame(MSIZE - 5, 1'b1, 1'b0, "frame_stall_wrap");
    run_frame(int'($urandom_range(0, MSIZE - 1)), 1'b0, 1'b0, "frame_rand");

    // Abort right in the strobe cycle of pixel 5.
    base = int'($urandom_range(0, MSIZE - 1));
    w = rand_weights();
    clear_stats();
    nostall = 1'b1;
    push_frame(w, base);
    issue_start(w, base, s);
    n = 0; t = 0;
    while (n < 6 && t < 200) begin
      if (data_in_valid) n++;
      if (n < 6) begin
        step();
        t++;
      end
    end
    check("abort_reached_pixel5", n, 6);
    abort = 1'b1;
    step();
    abort = 1'b0;
    flush_expect();
    check("abort_process_enable", int'(process_enable), 0);
    check("abort_busy", int'(busy), 0);
    step(30);
    check("abort_done_pulses", done_cnt, 0);
    check("abort_read_count", rd_cycles.size(), 6);
    check("abort_strobe_count", vld_cycles.size(), 6);
    check("abort_data_in_kept", int'(data_in), int'(mem[(base + 5) % MSIZE]));

    run_frame(base, 1'b0, 1'b0, "after_abort");

    // abort and start together while idle: abort wins.
    clear_stats();
    weights = rand_weights();
    frame_base = AW'($urandom);
    start = 1'b1;
    abort = 1'b1;
    step();
    start = 1'b0;
    abort = 1'b0;
    check("abort_start_busy", int'(busy), 0);
    step(15);
    check("abort_start_reads", rd_cycles.size(), 0);
    check("abort_start_done", done_cnt, 0);

    // Asynchronous reset in the middle of STREAM.
    clear_stats();
    w = rand_weights();
    push_frame(w, 'h20);
    issue_start(w, 'h20, s);
    step(24);
    check("pre_reset_streaming", int'(process_enable), 1);
    rst = 1'b0;
    #1;
    check("midreset_outputs", int'({mem_rd_en, mem_addr, weight_in_valid, weight_addr, weight_data,
                                    process_enable, data_in_valid, data_in, busy, done}), 0);
    flush_expect();
    last_data = '0;
    step(2);
    rst = 1'b1;
    step(2);
    run_frame('h20, 1'b0, 1'b0, "after_reset");

    // GAP=1 instance: back-to-back strobes.
    b_vld.delete();
    b_exp.delete();
    b_done_cyc = -1;
    base = int'($urandom_range(0, MSIZE - 1));
    for (int i = 0; i < NPIX; i++) b_exp.push_back(int'(mem[(base + i) % MSIZE]));
    b_weights = rand_weights();
    b_frame_base = AW'(base);
    b_start = 1'b1;
    s = cyc;
    step();
    b_start = 1'b0;
    t = 0;
    while (b_done_cyc < 0 && t < 300) begin
      step();
      t++;
    end
    check("b_strobe_count", b_vld.size(), NPIX);
    if (b_vld.size() == NPIX) begin
      n = 0;
      for (int i = 1; i < NPIX; i++) if (b_vld[i] != b_vld[0] + i) n++;
      check("b_first_strobe_cycle", b_vld[0] - s, 12);
      check("b_nonconsecutive", n, 0);
      check("b_done_after_last", b_done_cyc - b_vld[NPIX-1], 1);
    end
    check("b_done_cycle", b_done_cyc - s, 13 + (NPIX - 1) * GAP_B);
    check("b_leftover", b_exp.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/filter2d_feeder.md
# filter2d_feeder

Frame source for the 3x3 convolution engine. It loads the nine kernel weights over the engine's weight port. It then reads one frame row-major from a synchronous-read pixel memory and presents it as paced single-cycle `data_in_valid` strobes, with `data_in` held stable between strobes. It sits between the frame buffer and the filter's input side, in the `clk` domain.

## Interface
Parameters:
- BITWIDTH, 8, pixel and weight width
- COLS, 640, pixels per row
- ROWS, 480, rows per frame
- ADDR_W, 20, memory address width; must satisfy 2^ADDR_W ≥ COLS*ROWS
- GAP, 4, clk cycles between successive pixel strobes when not stalled; legal values ≥1

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- start  in  1  one-cycle pulse; begins a frame when idle
- abort  in  1  synchronous cancel of the current frame
- stall  in  1  downstream backpressure; blocks issue of new reads
- weights  in  9*BITWIDTH  kernel; slot k is [k*BITWIDTH +: BITWIDTH]; latched on accepted start
- frame_base  in  ADDR_W  first pixel address; latched on accepted start
- mem_rd_en  out  1  memory read strobe
- mem_addr  out  ADDR_W  read address
- mem_rdata  in  BITWIDTH  read data, valid the cycle after mem_rd_en
- weight_in_valid  out  1  weight write strobe
- weight_addr  out  4  weight slot, 0..8
- weight_data  out  BITWIDTH  weight value
- process_enable  out  1  engine enable
- data_in_valid  out  1  pixel strobe, one cycle wide
- data_in  out  BITWIDTH  pixel, held until the next strobe
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse at normal frame completion

## Operation
- FSM states: IDLE, LOAD_W, STREAM, DRAIN, DONE.
- IDLE: on start, latch `weights` and `frame_base`, clear the pixel index, and go to LOAD_W. start is ignored in every other state.
- LOAD_W: 9 consecutive cycles with weight_in_valid=1 and weight_addr=0,1,…,8. weight_data is the latched slot weight_addr. After slot 8, go to STREAM.
- STREAM: process_enable=1. An issue slot opens when the gap counter is 0.
  - In an open slot with stall=0: assert mem_rd_en, drive mem_addr=base+index, increment index, and reload the gap counter to GAP-1.
  - In an open slot with stall=1: nothing is issued and the slot stays open.
  - After index reaches COLS*ROWS-1 is issued, go to DRAIN.
- DRAIN: process_enable=1. Wait until the last in-flight strobe has been emitted, then go to DONE.
- DONE: done=1 for one cycle; process_enable=0; return to IDLE.
- Read pipeline: read issued in cycle t; mem_rdata is captured into data_in at the end of t+1; data_in_valid=1 in cycle t+2 only.
- data_in changes only on a capture edge.
- stall never cancels a read that has already been issued; its strobe is still emitted.
- abort (any non-IDLE state) takes effect at the next edge:
  - state goes to IDLE;
  - weight_in_valid, mem_rd_en, process_enable and any pending strobe are cleared;
  - done is not pulsed;
  - data_in keeps its value.
- abort has priority over start in the same cycle. An abort while IDLE has no effect.
- Index arithmetic is unsigned ADDR_W bits; base+index wraps modulo 2^ADDR_W.

## Timing
- Reset values: all outputs 0, state IDLE, data_in=0.
- start accepted at edge e: weight_in_valid=1 in cycles e+1..e+9.
- The first mem_rd_en is in cycle e+10. The first data_in_valid is in cycle e+12.
- Unstalled spacing between strobes is exactly GAP cycles. GAP=1 gives back-to-back strobes.
- done is asserted 1 cycle after the last strobe. busy falls together with done.
- Frame length unstalled: 9 + (COLS*ROWS-1)*GAP + 4 cycles from start to done, inclusive of the done cycle.
- Reset mid-frame forces every output to its reset value immediately, since reset is asynchronous.

## Test plan
- Weight load: weights={9 slots 8'h11..8'h99}, start → weight_addr 0..8 on 9 consecutive cycles with weight_data 8'h11..8'h99 in that order, no gaps.
- Small frame: COLS=4, ROWS=3, GAP=3, frame_base=0x100, memory content = address low byte → mem_addr 0x100..0x10B every 3 cycles. data_in_valid 12 times, 3 cycles apart, data_in 0x00..0x0B. data_in is stable between strobes. One done pulse.
- Back-to-back: GAP=1 → 12 consecutive data_in_valid cycles, then done the next cycle.
- Stall: stall=1 for 5 cycles covering the 4th issue slot → reads 0..2 unaffected; pixel 3 is issued on the first cycle stall=0. The in-flight strobe is still emitted. Total pixels 12, order unchanged.
- Abort after pixel 5: no further mem_rd_en or strobes, process_enable=0 next cycle, done never asserted. A new start then runs a full frame from pixel 0.
- Start while busy ignored. abort+start in IDLE-exit cycle → abort wins. rst low mid-STREAM → all outputs 0 immediately.
